// File: rtl/calc_pkg.sv
// calc_pkg: shared constants and types for the calculator sequencer, the ALU
// and their benches. One-hot ALU op encodings, key codes, error codes and the
// sequencer state enum live here so every consumer agrees on the encodings.
package calc_pkg;

  // One-hot ALU operation codes; all-zero means "no operation in flight".
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_STOP = 4'b0000;

  // Key codes above the digit range 0x00-0x0F.
  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_DIV = 5'h13;
  localparam logic [4:0] KEY_EQ  = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  // Error codes reported on err_code.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_A     = 3'd0,
    S_B     = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: op/a/b/busy/o bus between the calculator sequencer (master)
// and the ALU (slave).
//
// Handshake: the master raises alu_op to a one-hot code together with alu_a
// and alu_b and holds all three unchanged until it has taken the result. The
// slave registers alu_busy, so busy may only appear a couple of cycles after
// the op is raised; once busy is low after that, alu_o is the result. The
// master ends the transaction by returning alu_op to all-zero (STOP), which
// is also how an in-flight operation is aborted.
interface calc_ctrl_if;
  logic [3:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_busy;
  logic [7:0] alu_o;

  modport master (output alu_op, alu_a, alu_b, input alu_busy, alu_o);
  modport slave  (input alu_op, alu_a, alu_b, output alu_busy, alu_o);
endinterface

// File: rtl/calc_key_decode.sv
// calc_key_decode: purely combinational classification of a 5-bit key code
// into digit / operator / equals / clear. Unknown codes decode to nothing.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [4:0] key_code,
  output logic       is_digit,
  output logic       is_op,
  output logic [3:0] op_onehot,
  output logic       is_eq,
  output logic       is_clr
);

  // Classify the key; digits are every code with the top bit clear.
  always_comb begin
    is_digit  = ~key_code[4];
    is_op     = 1'b0;
    op_onehot = OP_STOP;
    is_eq     = 1'b0;
    is_clr    = 1'b0;
    case (key_code)
      KEY_ADD: begin is_op = 1'b1; op_onehot = OP_ADD; end
      KEY_SUB: begin is_op = 1'b1; op_onehot = OP_SUB; end
      KEY_MUL: begin is_op = 1'b1; op_onehot = OP_MUL; end
      KEY_DIV: begin is_op = 1'b1; op_onehot = OP_DIV; end
      KEY_EQ:  is_eq  = 1'b1;
      KEY_CLR: is_clr = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: calculator sequencer. Collects key events into operand A,
// operator and operand B, issues the op on the ALU bus, waits for the ALU to
// finish, then returns the 8-bit result with a one-cycle res_valid strobe.
// Optional build macro: CALC_ALU_TIMEOUT_EN adds a WAIT timeout that aborts
// the op and reports err_code 10 when the ALU stays busy too long.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int BUSY_GUARD  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic        key_ready,
  calc_ctrl_if.master alu,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic [1:0]  err_code,
  output state_t      state_dbg
);

  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCW-1:0] GUARD_CNT = WCW'(BUSY_GUARD);
`ifdef CALC_ALU_TIMEOUT_EN
  localparam logic [WCW-1:0] CNT_MAX = WCW'(TIMEOUT_CYC);
`else
  // Without the timeout the counter only needs to get past the guard window.
  localparam logic [WCW-1:0] CNT_MAX = GUARD_CNT;
`endif

  state_t         state;
  logic [3:0]     a_reg;
  logic [3:0]     b_reg;
  logic           a_set;
  logic           b_set;
  logic [3:0]     op_reg;
  logic [WCW-1:0] wait_cnt;

  logic           kd_digit;
  logic           kd_op;
  logic [3:0]     kd_onehot;
  logic           kd_eq;
  logic           kd_clr;
  logic [3:0]     digit;
  logic           key_take;
  logic           clr_hit;

  calc_key_decode u_key_decode (
    .key_code  (key_code),
    .is_digit  (kd_digit),
    .is_op     (kd_op),
    .op_onehot (kd_onehot),
    .is_eq     (kd_eq),
    .is_clr    (kd_clr)
  );

  assign digit     = key_code[3:0];
  // Ordinary keys count only while accepting; clear bypasses key_ready.
  assign key_take  = key_valid & key_ready;
  assign clr_hit   = key_valid & kd_clr;
  assign state_dbg = state;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_A;
      a_reg     <= 4'h0;
      b_reg     <= 4'h0;
      a_set     <= 1'b0;
      b_set     <= 1'b0;
      op_reg    <= OP_STOP;
      wait_cnt  <= '0;
      alu.alu_op <= OP_STOP;
      alu.alu_a <= 4'h0;
      alu.alu_b <= 4'h0;
      key_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_err   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      res_valid <= 1'b0;
      if (clr_hit) begin
        // Clear wins in every state and aborts any op in flight.
        state     <= S_A;
        a_reg     <= 4'h0;
        b_reg     <= 4'h0;
        a_set     <= 1'b0;
        b_set     <= 1'b0;
        op_reg    <= OP_STOP;
        wait_cnt  <= '0;
        alu.alu_op <= OP_STOP;
        alu.alu_a <= 4'h0;
        alu.alu_b <= 4'h0;
        key_ready <= 1'b1;
        res_data  <= 8'h00;
        res_err   <= 1'b0;
        err_code  <= ERR_NONE;
      end else begin
        case (state)
          S_A: begin
            if (key_take) begin
              if (kd_digit) begin
                a_reg <= digit;
                a_set <= 1'b1;
              end else if (kd_op && a_set) begin
                op_reg <= kd_onehot;
                state  <= S_B;
              end
            end
          end
          S_B: begin
            if (key_take) begin
              if (kd_digit) begin
                b_reg <= digit;
                b_set <= 1'b1;
              end else if (kd_op) begin
                op_reg <= kd_onehot;
              end else if (kd_eq && b_set) begin
                if (op_reg == OP_DIV && b_reg == 4'h0) begin
                  // Divide by zero is caught here; the ALU never sees it.
                  state    <= S_ERR;
                  res_err  <= 1'b1;
                  err_code <= ERR_DIV0;
                end else begin
                  // Bus is driven on entry so the op is visible in S_ISSUE.
                  state      <= S_ISSUE;
                  key_ready  <= 1'b0;
                  alu.alu_op <= op_reg;
                  alu.alu_a  <= a_reg;
                  alu.alu_b  <= b_reg;
                end
              end
            end
          end
          S_ISSUE: begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
          S_WAIT: begin
            // Busy is meaningless until the ALU has had time to register it.
            if (wait_cnt >= GUARD_CNT && !alu.alu_busy) begin
              res_data   <= alu.alu_o;
              res_valid  <= 1'b1;
              alu.alu_op <= OP_STOP;
              state      <= S_DONE;
            end
`ifdef CALC_ALU_TIMEOUT_EN
            else if (wait_cnt == CNT_MAX) begin
              alu.alu_op <= OP_STOP;
              state      <= S_ERR;
              res_err    <= 1'b1;
              err_code   <= ERR_TIMEOUT;
              key_ready  <= 1'b1;
            end
`endif
            else if (wait_cnt != CNT_MAX) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DONE: begin
            state     <= S_A;
            a_set     <= 1'b0;
            b_set     <= 1'b0;
            key_ready <= 1'b1;
          end
          S_ERR: begin
            // Only clear leaves this state.
            state <= S_ERR;
          end
          default: begin
            state     <= S_A;
            key_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: self-checking bench for calc_ctrl with a behavioural ALU
// whose busy time is set per transaction.
module tb_calc_ctrl;
  import calc_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_err;
  logic [1:0] err_code;
  state_t     state_dbg;

  always #5 clk = ~clk;

  calc_ctrl_if alu_bus ();

  calc_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .alu       (alu_bus),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .err_code  (err_code),
    .state_dbg (state_dbg)
  );

  // ---------------- ALU model ----------------
  int         busy_len;
  logic       busy_stuck;
  logic       alu_started;
  int         alu_cnt;

  function automatic logic [7:0] alu_calc(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      OP_ADD: r = {4'h0, a} + {4'h0, b};
      OP_SUB: r = {4'h0, a} - {4'h0, b};
      OP_MUL: r = {4'h0, a} * {4'h0, b};
      OP_DIV: r = (b == 4'h0) ? 8'hFF : {4'h0, a / b};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_bus.alu_busy <= 1'b0;
      alu_bus.alu_o    <= 8'h00;
      alu_started      <= 1'b0;
      alu_cnt          <= 0;
    end else if (alu_bus.alu_op == OP_STOP) begin
      alu_started      <= 1'b0;
      alu_bus.alu_busy <= 1'b0;
      alu_cnt          <= 0;
    end else if (!alu_started) begin
      alu_started      <= 1'b1;
      alu_bus.alu_o    <= alu_calc(alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b);
      alu_bus.alu_busy <= busy_stuck || (busy_len != 0);
      alu_cnt          <= busy_len;
    end else if (alu_cnt != 0) begin
      alu_cnt          <= alu_cnt - 1;
      alu_bus.alu_busy <= busy_stuck || (alu_cnt > 1);
    end else begin
      alu_bus.alu_busy <= busy_stuck;
    end
  end

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];
  logic       op_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && res_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_unexpected: res_valid with res_data=%0h, want no result", res_data);
      end else begin
        check("sb_result", {24'h0, res_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (alu_bus.alu_op != OP_STOP) op_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  // All drivers run in the phase just after a rising edge.
  task automatic press(input logic [4:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 5'h00;
    @(posedge clk); #1;
  endtask

  task automatic clear_key();
    key_valid = 1'b1;
    key_code  = KEY_CLR;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 5'h00;
  endtask

  // Press '=', then follow the op through to its result strobe.
  task automatic finish_calc(input logic [3:0] a, input logic [3:0] b, input int len,
                             input logic [3:0] exp_op, input logic [7:0] exp_res,
                             input string name);
    logic held_ok;
    logic got;
    int   lat;
    busy_len   = len;
    busy_stuck = 1'b0;
    exp_q.push_back(exp_res);
    key_valid = 1'b1;
    key_code  = KEY_EQ;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 5'h00;
    check({name, "_issue_op"}, {28'h0, alu_bus.alu_op}, {28'h0, exp_op});
    held_ok = 1'b1;
    got     = 1'b0;
    lat     = 0;
    for (int i = 0; i < 200; i++) begin
      if (!(alu_bus.alu_op == exp_op && alu_bus.alu_a == a && alu_bus.alu_b == b))
        held_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (res_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_result_seen"}, {31'h0, got}, 32'h1);
    check({name, "_op_held"}, {31'h0, held_ok}, 32'h1);
    if (len == 0) check({name, "_latency"}, lat, 4);
    check({name, "_op_stop"}, {28'h0, alu_bus.alu_op}, {28'h0, OP_STOP});
    check({name, "_res_data"}, {24'h0, res_data}, {24'h0, exp_res});
    @(posedge clk); #1;
    check({name, "_strobe_once"}, {31'h0, res_valid}, 32'h0);
    check({name, "_back_to_a"}, 32'(state_dbg), 32'(S_A));
    check({name, "_hold_data"}, {24'h0, res_data}, {24'h0, exp_res});
  endtask

  task automatic run_calc(input logic [3:0] a, input logic [4:0] opk, input logic [3:0] b,
                          input int len, input logic [3:0] exp_op, input logic [7:0] exp_res,
                          input string name);
    press({1'b0, a});
    press(opk);
    press({1'b0, b});
    finish_calc(a, b, len, exp_op, exp_res, name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] a;
    logic [4:0] opk;
    logic [3:0] b;
    int         len;
    logic [3:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    vt[0] = '{4'h3, KEY_ADD, 4'h4, 0,  OP_ADD, 8'h07};
    vt[1] = '{4'hF, KEY_MUL, 4'hF, 10, OP_MUL, 8'hE1};
    vt[2] = '{4'h2, KEY_SUB, 4'h5, 3,  OP_SUB, 8'hFD};
    vt[3] = '{4'h8, KEY_DIV, 4'h2, 1,  OP_DIV, 8'h04};
    vt[4] = '{4'hA, KEY_ADD, 4'hF, 0,  OP_ADD, 8'h19};
    vt[5] = '{4'h7, KEY_MUL, 4'h6, 2,  OP_MUL, 8'h2A};
    vt[6] = '{4'h0, KEY_SUB, 4'h1, 0,  OP_SUB, 8'hFF};
    vt[7] = '{4'hF, KEY_DIV, 4'h4, 5,  OP_DIV, 8'h03};

    rst        = 1'b0;
    key_valid  = 1'b0;
    key_code   = 5'h00;
    busy_len   = 0;
    busy_stuck = 1'b0;
    op_seen    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    check("rst_state", 32'(state_dbg), 32'(S_A));
    check("rst_alu_op", {28'h0, alu_bus.alu_op}, 32'h0);
    check("rst_alu_a", {28'h0, alu_bus.alu_a}, 32'h0);
    check("rst_alu_b", {28'h0, alu_bus.alu_b}, 32'h0);
    check("rst_res_valid", {31'h0, res_valid}, 32'h0);
    check("rst_res_data", {24'h0, res_data}, 32'h0);
    check("rst_res_err", {31'h0, res_err}, 32'h0);
    check("rst_err_code", {30'h0, err_code}, 32'h0);
    check("rst_key_ready", {31'h0, key_ready}, 32'h1);

    // Ignored keys, last-digit-wins, operator replacement.
    press(KEY_ADD);
    check("op_without_a", 32'(state_dbg), 32'(S_A));
    press(KEY_EQ);
    check("eq_in_a", 32'(state_dbg), 32'(S_A));
    press(5'h01);
    press(5'h05);
    press(KEY_MUL);
    press(KEY_SUB);
    press(KEY_EQ);
    check("eq_without_b", 32'(state_dbg), 32'(S_B));
    press(5'h02);
    press(5'h06);
    finish_calc(4'h5, 4'h6, 0, OP_SUB, 8'hFF, "last_digit");

    // Table-driven arithmetic.
    for (int i = 0; i < 8; i++)
      run_calc(vt[i].a, vt[i].opk, vt[i].b, vt[i].len, vt[i].exp_op, vt[i].exp_res,
               $sformatf("vec%0d", i));

    // Reset in the middle of WAIT, then a normal op afterwards.
    busy_stuck = 1'b1;
    press(5'h02);
    press(KEY_SUB);
    press(5'h05);
    press(KEY_EQ);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_wait", 32'(state_dbg), 32'(S_WAIT));
    rst = 1'b0;
    #1;
    check("async_rst_op", {28'h0, alu_bus.alu_op}, 32'h0);
    check("async_rst_a", {28'h0, alu_bus.alu_a}, 32'h0);
    check("async_rst_data", {24'h0, res_data}, 32'h0);
    check("async_rst_state", 32'(state_dbg), 32'(S_A));
    check("async_rst_ready", {31'h0, key_ready}, 32'h1);
    @(posedge clk); #1;
    rst        = 1'b1;
    busy_stuck = 1'b0;
    @(posedge clk); #1;
    run_calc(4'h2, KEY_SUB, 4'h5, 0, OP_SUB, 8'hFD, "post_rst");

    // Divide by zero: no op issued, error held, only clear leaves.
    op_seen = 1'b0;
    press(5'h09);
    press(KEY_DIV);
    press(5'h00);
    press(KEY_EQ);
    repeat (3) @(posedge clk);
    #1;
    check("div0_no_issue", {31'h0, op_seen}, 32'h0);
    check("div0_state", 32'(state_dbg), 32'(S_ERR));
    check("div0_err", {31'h0, res_err}, 32'h1);
    check("div0_code", {30'h0, err_code}, {30'h0, ERR_DIV0});
    press(5'h03);
    check("div0_key_ignored", 32'(state_dbg), 32'(S_ERR));
    clear_key();
    check("div0_clr_err", {31'h0, res_err}, 32'h0);
    check("div0_clr_code", {30'h0, err_code}, 32'h0);
    check("div0_clr_state", 32'(state_dbg), 32'(S_A));
    @(posedge clk); #1;

    // Clear during WAIT aborts the op; digits in WAIT are dropped.
    busy_stuck = 1'b1;
    press(5'h06);
    press(KEY_ADD);
    press(5'h01);
    press(KEY_EQ);
    repeat (3) @(posedge clk);
    #1;
    check("wait_key_ready", {31'h0, key_ready}, 32'h0);
    press(5'h07);
    check("wait_digit_state", 32'(state_dbg), 32'(S_WAIT));
    check("wait_digit_a", {28'h0, alu_bus.alu_a}, 32'h6);
    check("wait_digit_op", {28'h0, alu_bus.alu_op}, {28'h0, OP_ADD});
    clear_key();
    check("wait_clr_op", {28'h0, alu_bus.alu_op}, 32'h0);
    check("wait_clr_state", 32'(state_dbg), 32'(S_A));
    check("wait_clr_valid", {31'h0, res_valid}, 32'h0);
    busy_stuck = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    press(KEY_ADD);
    check("wait_clr_a_unset", 32'(state_dbg), 32'(S_A));

    // ALU busy stuck high.
    busy_stuck = 1'b1;
    press(5'h04);
    press(KEY_MUL);
    press(5'h03);
    press(KEY_EQ);
`ifdef CALC_ALU_TIMEOUT_EN
    got = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (res_err) begin
        got = 1'b1;
        break;
      end
    end
    check("tmo_seen", {31'h0, got}, 32'h1);
    check("tmo_code", {30'h0, err_code}, {30'h0, ERR_TIMEOUT});
    check("tmo_op_stop", {28'h0, alu_bus.alu_op}, 32'h0);
    check("tmo_state", 32'(state_dbg), 32'(S_ERR));
`else
    got = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("stuck_state", 32'(state_dbg), 32'(S_WAIT));
    check("stuck_op_held", {28'h0, alu_bus.alu_op}, {28'h0, OP_MUL});
    check("stuck_no_err", {31'h0, res_err}, {31'h0, got});
    check("stuck_code", {30'h0, err_code}, 32'h0);
`endif
    clear_key();
    busy_stuck = 1'b0;
    check("stuck_clr_state", 32'(state_dbg), 32'(S_A));
    check("stuck_clr_err", {31'h0, res_err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
